// File: rtl/adc_sample_averager.sv
// Maps five ADC sequencer channels to slots, averages 2^AVG_LOG2 complete packets per
// slot and publishes rounded 12-bit means, deferring publication while hold is high.
module adc_sample_averager #(
  parameter int         AVG_LOG2 = 3,
  parameter logic [4:0] CH0_ID   = 5'h03,
  parameter logic [4:0] CH1_ID   = 5'h06,
  parameter logic [4:0] CH2_ID   = 5'h01,
  parameter logic [4:0] CH3_ID   = 5'h02,
  parameter logic [4:0] CH4_ID   = 5'h04
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        hold,
  input  logic        adc_response_valid,
  input  logic [4:0]  adc_response_channel,
  input  logic [11:0] adc_response_data,
  input  logic        adc_response_endofpacket,
  output logic [15:0] adc_chan0,
  output logic [15:0] adc_chan1,
  output logic [15:0] adc_chan2,
  output logic [15:0] adc_chan3,
  output logic [15:0] adc_chan4,
  output logic        data_update,
  output logic [7:0]  err_count,
  output logic [7:0]  ovr_count
);

  localparam int                   NSLOT    = 5;
  localparam int                   PKTS     = 1 << AVG_LOG2;
  localparam logic [3:0]           PKT_LAST = 4'(PKTS - 1);
  localparam logic [16:0]          ROUND    = 17'(PKTS >> 1);
  localparam logic [NSLOT*5-1:0]   CH_IDS   = {CH4_ID, CH3_ID, CH2_ID, CH1_ID, CH0_ID};

  typedef enum logic {ST_SYNC, ST_ACCUM} state_t;

  state_t           state_reg;
  logic [16:0]      acc_reg   [NSLOT];
  logic [11:0]      pend_reg  [NSLOT];
  logic [11:0]      chan_reg  [NSLOT];
  logic [NSLOT-1:0] seen_reg;
  logic             dup_reg;
  logic [3:0]       pkt_cnt_reg;
  logic             pending_reg;
  logic             data_update_reg;
  logic [7:0]       err_count_reg;
  logic [7:0]       ovr_count_reg;

  logic             beat_accum;
  logic             eop_accum;
  logic [NSLOT-1:0] hit;
  logic [NSLOT-1:0] seen_next;
  logic             dup_next;
  logic             pkt_good;
  logic             pkt_bad;
  logic             win_done;
  logic             publish;
  logic [16:0]      acc_next  [NSLOT];
  logic [16:0]      rounded   [NSLOT];
  logic [11:0]      mean_next [NSLOT];

  assign beat_accum = enable && (state_reg == ST_ACCUM) && adc_response_valid;
  assign eop_accum  = beat_accum && adc_response_endofpacket;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      assign hit[gi]       = beat_accum && (adc_response_channel == CH_IDS[gi*5 +: 5]);
      assign acc_next[gi]  = acc_reg[gi] + (hit[gi] ? {5'd0, adc_response_data} : 17'd0);
      assign rounded[gi]   = (acc_next[gi] + ROUND) >> AVG_LOG2;
      assign mean_next[gi] = (rounded[gi] > 17'd4095) ? 12'hFFF : rounded[gi][11:0];
    end
  endgenerate

  // The EOP beat itself counts toward both completeness and duplicate detection.
  assign seen_next = seen_reg | hit;
  assign dup_next  = dup_reg | (|(hit & seen_reg));
  assign pkt_good  = eop_accum && (&seen_next) && !dup_next;
  assign pkt_bad   = eop_accum && !pkt_good;
  assign win_done  = pkt_good && (pkt_cnt_reg == PKT_LAST);
  assign publish   = pending_reg && !hold;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_SYNC;
      seen_reg        <= '0;
      dup_reg         <= 1'b0;
      pkt_cnt_reg     <= '0;
      pending_reg     <= 1'b0;
      data_update_reg <= 1'b0;
      err_count_reg   <= '0;
      ovr_count_reg   <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        acc_reg[k]  <= '0;
        pend_reg[k] <= '0;
        chan_reg[k] <= '0;
      end
    end else begin
      data_update_reg <= publish;
      if (publish) begin
        for (int k = 0; k < NSLOT; k++) chan_reg[k] <= pend_reg[k];
      end

      // A completion on the publishing edge re-arms pending without being an overrun.
      if (win_done) begin
        for (int k = 0; k < NSLOT; k++) pend_reg[k] <= mean_next[k];
      end
      pending_reg <= win_done || (pending_reg && !publish);
      if (win_done && pending_reg && !publish && (ovr_count_reg != 8'hFF))
        ovr_count_reg <= ovr_count_reg + 8'd1;
      if (pkt_bad && (err_count_reg != 8'hFF))
        err_count_reg <= err_count_reg + 8'd1;

      if (!enable) begin
        state_reg   <= ST_SYNC;
        seen_reg    <= '0;
        dup_reg     <= 1'b0;
        pkt_cnt_reg <= '0;
        for (int k = 0; k < NSLOT; k++) acc_reg[k] <= '0;
      end else if (state_reg == ST_SYNC) begin
        if (adc_response_valid && adc_response_endofpacket)
          state_reg <= ST_ACCUM;
      end else if (eop_accum) begin
        seen_reg <= '0;
        dup_reg  <= 1'b0;
        if (pkt_good && !win_done) begin
          pkt_cnt_reg <= pkt_cnt_reg + 4'd1;
          for (int k = 0; k < NSLOT; k++) acc_reg[k] <= acc_next[k];
        end else begin
          pkt_cnt_reg <= '0;
          for (int k = 0; k < NSLOT; k++) acc_reg[k] <= '0;
        end
      end else if (beat_accum) begin
        seen_reg <= seen_next;
        dup_reg  <= dup_next;
        for (int k = 0; k < NSLOT; k++) acc_reg[k] <= acc_next[k];
      end
    end
  end

  assign adc_chan0   = {4'b0, chan_reg[0]};
  assign adc_chan1   = {4'b0, chan_reg[1]};
  assign adc_chan2   = {4'b0, chan_reg[2]};
  assign adc_chan3   = {4'b0, chan_reg[3]};
  assign adc_chan4   = {4'b0, chan_reg[4]};
  assign data_update = data_update_reg;
  assign err_count   = err_count_reg;
  assign ovr_count   = ovr_count_reg;

endmodule
